// File: rtl/npu_bram_pkg.sv
// Shared types and bank decode for the BRAM bank crossbar.
// BRAM_XBAR_INTERLEAVE_EN selects low-order interleave instead of high-bit bank select.
package npu_bram_pkg;

  localparam int unsigned MST_ID_W   = 4;
  localparam int unsigned BANK_SEL_W = 4;
  localparam int unsigned ADDR_MAX_W = 64;

  typedef logic [BANK_SEL_W-1:0] bank_sel_t;
  typedef logic [MST_ID_W-1:0]   mst_id_t;

  typedef struct packed {
    logic    vld;
    mst_id_t id;
  } rd_track_t;

  function automatic bank_sel_t bank_decode(input logic [ADDR_MAX_W-1:0] addr,
                                            input int unsigned addr_w,
                                            input int unsigned sel_w);
    logic [ADDR_MAX_W-1:0] mask;
    mask = (ADDR_MAX_W'(1) << sel_w) - ADDR_MAX_W'(1);
`ifdef BRAM_XBAR_INTERLEAVE_EN
    return bank_sel_t'(addr & mask & {ADDR_MAX_W{addr_w != 0}});
`else
    return bank_sel_t'((addr >> (addr_w - sel_w)) & mask);
`endif
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins,
// pointer moves past the winner when adv is set and a grant is made.
module rr_arbiter #(
  parameter int N = 2,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            adv,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] ptr;
  logic            found;
  int              idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found       = 1'b1;
          gnt[idx]    = 1'b1;
          gnt_id      = ID_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= ID_W'((int'(gnt_id) + 1) % N);
    end
  end

endmodule

// File: rtl/bram_bank_xbar.sv
// Multi-master crossbar over single-port BRAM banks with per-bank round-robin
// and fixed-latency read return. BRAM_XBAR_INTERLEAVE_EN selects low-order interleave.
module bram_bank_xbar
  import npu_bram_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_NUM        = 4,
  parameter int MST_NUM         = 2,
  parameter int RD_LAT          = 1,
  parameter int BANK_ADDR_WIDTH = ADDR_WIDTH - $clog2(BANK_NUM)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [MST_NUM-1:0]                        m_valid,
  output logic [MST_NUM-1:0]                        m_ready,
  input  logic [MST_NUM-1:0][ADDR_WIDTH-1:0]        m_addr,
  input  logic [MST_NUM-1:0][DATA_WIDTH-1:0]        m_wdata,
  input  logic [MST_NUM-1:0]                        m_we,
  output logic [MST_NUM-1:0]                        m_rvalid,
  output logic [MST_NUM-1:0][DATA_WIDTH-1:0]        m_rdata,
  output logic [BANK_NUM-1:0][BANK_ADDR_WIDTH-1:0]  bram_addr,
  output logic [BANK_NUM-1:0][DATA_WIDTH-1:0]       bram_wdata,
  output logic [BANK_NUM-1:0]                       bram_we,
  output logic [BANK_NUM-1:0]                       bram_en,
  input  logic [BANK_NUM-1:0][DATA_WIDTH-1:0]       bram_rdata
);

  localparam int SEL_W = $clog2(BANK_NUM);
  localparam int ID_W  = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;

  bank_sel_t                  m_bank  [MST_NUM];
  logic [BANK_ADDR_WIDTH-1:0] m_baddr [MST_NUM];
  logic [MST_NUM-1:0]         bank_req [BANK_NUM];
  logic [MST_NUM-1:0]         gnt      [BANK_NUM];
  logic [ID_W-1:0]            gnt_id   [BANK_NUM];
  rd_track_t                  rd_pipe  [BANK_NUM][RD_LAT];

  always_comb begin
    for (int i = 0; i < MST_NUM; i++) begin
      m_bank[i] = bank_decode(ADDR_MAX_W'(m_addr[i]), ADDR_WIDTH, SEL_W);
`ifdef BRAM_XBAR_INTERLEAVE_EN
      m_baddr[i] = m_addr[i][ADDR_WIDTH-1:SEL_W];
`else
      m_baddr[i] = m_addr[i][BANK_ADDR_WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      bank_req[b] = '0;
      for (int i = 0; i < MST_NUM; i++) begin
        bank_req[b][i] = m_valid[i] && (m_bank[i] == bank_sel_t'(b));
      end
    end
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    rr_arbiter #(.N(MST_NUM)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (bank_req[b]),
      .adv    (1'b1),
      .gnt    (gnt[b]),
      .gnt_id (gnt_id[b])
    );
  end

  // A master decodes to exactly one bank, so OR-ing grants never double-counts.
  always_comb begin
    m_ready = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      m_ready = m_ready | gnt[b];
    end
  end

  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      bram_en[b]    = |gnt[b];
      bram_we[b]    = 1'b0;
      bram_addr[b]  = '0;
      bram_wdata[b] = '0;
      if (bram_en[b]) begin
        bram_we[b]    = m_we[gnt_id[b]];
        bram_addr[b]  = m_baddr[gnt_id[b]];
        bram_wdata[b] = m_wdata[gnt_id[b]];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BANK_NUM; b++) begin
      if (rst) begin
        for (int k = 0; k < RD_LAT; k++) begin
          rd_pipe[b][k] <= '0;
        end
      end else begin
        rd_pipe[b][0] <= '{vld: bram_en[b] & ~bram_we[b], id: mst_id_t'(gnt_id[b])};
        for (int k = 1; k < RD_LAT; k++) begin
          rd_pipe[b][k] <= rd_pipe[b][k-1];
        end
      end
    end
  end

  // Reset also masks the tail so a latency-1 read cannot surface during reset.
  always_comb begin
    m_rvalid = '0;
    m_rdata  = '0;
    if (!rst) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        for (int i = 0; i < MST_NUM; i++) begin
          if (rd_pipe[b][RD_LAT-1].vld && rd_pipe[b][RD_LAT-1].id == mst_id_t'(i)) begin
            m_rvalid[i] = 1'b1;
            m_rdata[i]  = bram_rdata[b];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_bank_xbar.sv
// Bench for bram_bank_xbar: directed cases plus random traffic against a
// transaction-level model with its own memory and return queue.
module tb_bram_bank_xbar;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int NM = 2;
  localparam int RL = 2;
  localparam int BAW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [NM-1:0]           m_valid, m_ready, m_we, m_rvalid;
  logic [NM-1:0][AW-1:0]   m_addr;
  logic [NM-1:0][DW-1:0]   m_wdata, m_rdata;
  logic [NB-1:0][BAW-1:0]  bram_addr;
  logic [NB-1:0][DW-1:0]   bram_wdata, bram_rdata;
  logic [NB-1:0]           bram_we, bram_en;

  bram_bank_xbar #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(NB), .MST_NUM(NM), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_we(m_we), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
    .bram_en(bram_en), .bram_rdata(bram_rdata)
  );

  typedef struct { int due; int m; logic [31:0] d; } ret_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ptr [NB];
  ret_t        rq [$];
  logic [31:0] ref_mem [int];
  logic [31:0] bram_mem [int];
  logic [31:0] line [NB][RL];

  logic [NM-1:0]          e_ready, e_rvalid;
  logic [NB-1:0]          e_en, e_we;
  logic [NB-1:0][BAW-1:0] e_addr;
  logic [NB-1:0][DW-1:0]  e_wdata;
  logic [NM-1:0][DW-1:0]  e_rdata;
  int                     e_g [NB];

  function automatic int bank_of(input logic [AW-1:0] a);
`ifdef BRAM_XBAR_INTERLEAVE_EN
    return int'(a) % NB;
`else
    return int'(a) / (1 << BAW);
`endif
  endfunction

  function automatic int loc_of(input logic [AW-1:0] a);
`ifdef BRAM_XBAR_INTERLEAVE_EN
    return int'(a) / NB;
`else
    return int'(a) % (1 << BAW);
`endif
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int b, input int loc);
`ifdef BRAM_XBAR_INTERLEAVE_EN
    return AW'(loc * NB + b);
`else
    return AW'(b * (1 << BAW) + loc);
`endif
  endfunction

  function automatic logic [31:0] init_val(input int key);
    return (32'(key) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_eval();
    e_ready = '0; e_rvalid = '0; e_en = '0; e_we = '0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    for (int b = 0; b < NB; b++) e_g[b] = -1;
    if (rst) begin
      rq.delete();
    end else begin
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < NM; k++) begin
          int idx;
          idx = (ptr[b] + k) % NM;
          if (e_g[b] < 0 && m_valid[idx] && bank_of(m_addr[idx]) == b) e_g[b] = idx;
        end
        if (e_g[b] >= 0) begin
          e_ready[e_g[b]] = 1'b1;
          e_en[b]    = 1'b1;
          e_we[b]    = m_we[e_g[b]];
          e_addr[b]  = BAW'(loc_of(m_addr[e_g[b]]));
          e_wdata[b] = m_wdata[e_g[b]];
        end
      end
      for (int j = rq.size() - 1; j >= 0; j--) begin
        if (rq[j].due == cyc) begin
          e_rvalid[rq[j].m] = 1'b1;
          e_rdata[rq[j].m]  = rq[j].d;
          rq.delete(j);
        end
      end
    end
  endtask

  task automatic compare();
    chk("m_ready", 128'(m_ready), 128'(e_ready));
    chk("bram_en", 128'(bram_en), 128'(e_en));
    chk("bram_we", 128'(bram_we), 128'(e_we));
    chk("bram_addr", 128'(bram_addr), 128'(e_addr));
    chk("bram_wdata", 128'(bram_wdata), 128'(e_wdata));
    chk("m_rvalid", 128'(m_rvalid), 128'(e_rvalid));
    chk("m_rdata", 128'(m_rdata), 128'(e_rdata));
  endtask

  task automatic bram_step();
    for (int b = 0; b < NB; b++) begin
      logic [31:0] v;
      int key;
      v = $urandom;
      if (bram_en[b] === 1'b1) begin
        key = b * 65536 + int'(bram_addr[b]);
        if (bram_we[b]) bram_mem[key] = bram_wdata[b];
        else v = bram_mem.exists(key) ? bram_mem[key] : init_val(key);
      end
      for (int k = RL - 1; k > 0; k--) line[b][k] = line[b][k-1];
      line[b][0] = v;
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      for (int b = 0; b < NB; b++) ptr[b] = 0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (e_g[b] >= 0) begin
          int key;
          ptr[b] = (e_g[b] + 1) % NM;
          key = b * 65536 + loc_of(m_addr[e_g[b]]);
          if (m_we[e_g[b]]) ref_mem[key] = m_wdata[e_g[b]];
          else rq.push_back('{cyc + RL, e_g[b], ref_mem.exists(key) ? ref_mem[key] : init_val(key)});
        end
      end
    end
    cyc++;
  endtask

  task automatic run_cycle(input logic r, input logic [1:0] v, input logic [1:0] we,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1);
    @(posedge clk);
    #1;
    rst = r; m_valid = v; m_we = we;
    m_addr[0] = a0; m_addr[1] = a1; m_wdata[0] = d0; m_wdata[1] = d1;
    for (int b = 0; b < NB; b++) bram_rdata[b] = line[b][RL-1];
    @(negedge clk);
    model_eval();
    compare();
    bram_step();
    model_commit();
  endtask

  task automatic idle();
    run_cycle(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  initial begin
    logic [1:0]        rv, rwe;
    logic [1:0][15:0]  ra;
    logic [1:0][31:0]  rd;
    logic              rr;
    for (int b = 0; b < NB; b++) begin
      ptr[b] = 0;
      for (int k = 0; k < RL; k++) line[b][k] = '0;
    end
    rst = 1'b1; m_valid = '0; m_we = '0; m_addr = '0; m_wdata = '0; bram_rdata = '0;

    for (int n = 0; n < 3; n++) run_cycle(1'b1, 2'b11, 2'b00, 16'h4000, 16'h4000, '0, '0);
    chk("rst_ready", 128'(m_ready), 128'(2'b00));
    chk("rst_en", 128'(bram_en), 128'(4'b0000));
    chk("rst_rvalid", 128'(m_rvalid), 128'(2'b00));

`ifndef BRAM_XBAR_INTERLEAVE_EN
    // single master on bank 1
    run_cycle(1'b0, 2'b01, 2'b01, 16'h4010, '0, 32'h12345678, '0);
    chk("t1_wr_ready", 128'(m_ready), 128'(2'b01));
    run_cycle(1'b0, 2'b01, 2'b00, 16'h4010, '0, '0, '0);
    chk("t1_en", 128'(bram_en), 128'(4'b0010));
    chk("t1_addr", 128'(bram_addr[1]), 128'(14'h0010));
    idle();
    chk("t1_rv_early", 128'(m_rvalid), 128'(2'b00));
    idle();
    chk("t1_rvalid", 128'(m_rvalid), 128'(2'b01));
    chk("t1_rdata", 128'(m_rdata[0]), 128'(32'h12345678));

    // both masters hammer bank 2
    for (int k = 0; k < 8; k++) begin
      run_cycle(1'b0, 2'b11, 2'b00, 16'h8000, 16'h8004, '0, '0);
      chk("t2_ready", 128'(m_ready), 128'((k % 2 == 0) ? 2'b01 : 2'b10));
      if (k >= 2) chk("t2_rvalid", 128'(m_rvalid), 128'((k % 2 == 0) ? 2'b01 : 2'b10));
    end
    idle(); idle();

    // different banks in parallel
    run_cycle(1'b0, 2'b11, 2'b00, 16'h0004, 16'hC004, '0, '0);
    chk("t3_ready", 128'(m_ready), 128'(2'b11));
    chk("t3_en", 128'(bram_en), 128'(4'b1001));
    idle(); idle();
    chk("t3_rvalid", 128'(m_rvalid), 128'(2'b11));

    // write then read back
    run_cycle(1'b0, 2'b10, 2'b10, '0, 16'h8020, '0, 32'hDEADBEEF);
    chk("t4_ready", 128'(m_ready), 128'(2'b10));
    chk("t4_we", 128'(bram_we), 128'(4'b0100));
    run_cycle(1'b0, 2'b10, 2'b00, '0, 16'h8020, '0, '0);
    idle();
    chk("t4_no_wr_resp", 128'(m_rvalid), 128'(2'b00));
    idle();
    chk("t4_rvalid", 128'(m_rvalid), 128'(2'b10));
    chk("t4_rdata", 128'(m_rdata[1]), 128'(32'hDEADBEEF));

    // read in flight killed by reset
    run_cycle(1'b0, 2'b01, 2'b00, 16'h0100, '0, '0, '0);
    chk("t5_ready", 128'(m_ready), 128'(2'b01));
    run_cycle(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    chk("t5_rv_rst", 128'(m_rvalid), 128'(2'b00));
    idle();
    chk("t5_rv_a", 128'(m_rvalid), 128'(2'b00));
    idle();
    chk("t5_rv_b", 128'(m_rvalid), 128'(2'b00));
    run_cycle(1'b0, 2'b11, 2'b00, 16'hC000, 16'hC008, '0, '0);
    chk("t5_first_gnt", 128'(m_ready), 128'(2'b01));
    idle(); idle();
`else
    run_cycle(1'b0, 2'b01, 2'b00, 16'h0005, '0, '0, '0);
    chk("t6_en", 128'(bram_en), 128'(4'b0010));
    chk("t6_addr", 128'(bram_addr[1]), 128'(14'h0001));
    idle(); idle();
`endif

    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NM; i++) begin
        if (m_valid[i] && !e_ready[i]) begin
          rv[i] = m_valid[i]; rwe[i] = m_we[i]; ra[i] = m_addr[i]; rd[i] = m_wdata[i];
        end else begin
          rv[i]  = ($urandom_range(0, 99) < 70);
          rwe[i] = ($urandom_range(0, 3) == 0);
          ra[i]  = mk_addr($urandom_range(0, NB - 1), $urandom_range(0, 7));
          rd[i]  = $urandom;
        end
      end
      run_cycle(rr, rv, rwe, ra[0], ra[1], rd[0], rd[1]);
    end
    for (int n = 0; n < RL + 1; n++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
